if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Instruction queue and pipeline register between the instruction-fetch stage and the decode stage of the MIPS datapath.
- Captures each fetched {PC, instruction} pair and buffers up to DEPTH entries so fetch can run ahead of a stalled decoder.
- Presents the oldest entry to decode with a valid/ready handshake.
- Supports a single-cycle flush for branch/jump redirects.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents a valid pc/instruction this cycle.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  32  PC of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- flush  input  1  discard all queued entries (redirect).
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction of the head entry.
- out_pc_plus4  output  32  out_pc + 4.
- out_misaligned  output  1  head PC is not word-aligned.
- count  output  PTR_W+1  number of occupied entries.

Behaviour:
- Reset, asynchronous on rst_n low:
  - wr_ptr = 0, rd_ptr = 0, count = 0, out_valid = 0.
  - out_pc = 0, out_instr = 0, out_pc_plus4 = 0, out_misaligned = 0.
  - in_ready = 1 once rst_n is high.
- Transfer events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (count < DEPTH). It does not depend on out_ready, so a full queue refuses input even if a pop occurs in the same cycle.
- Push: writes {in_pc, in_instr} at wr_ptr. wr_ptr increments modulo DEPTH and wraps from DEPTH-1 to 0.
- Pop: rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together (allowed whenever 0 < count < DEPTH).
- Latency: an entry pushed at edge N drives out_* in the cycle after edge N, when the queue was empty. This is 1-cycle fetch-to-decode latency.
- Head outputs:
  - out_valid = (count != 0).
  - When out_valid = 1: out_pc and out_instr come from the rd_ptr entry.
  - When out_valid = 0: out_pc and out_instr are forced to 0. An all-zero instruction is a NOP (sll $0,$0,0).
- out_pc_plus4 = out_pc + 4, truncated to 32 bits, so 0xFFFFFFFC gives 0x00000000. It is 0 when out_valid = 0.
- out_misaligned = out_valid & (out_pc[1:0] != 0). Informational only; the entry is still delivered.
- Flush is synchronous:
  - At the edge, wr_ptr, rd_ptr and count return to 0.
  - Flush has priority: a push or pop in the same cycle is discarded and has no effect.
  - out_valid = 0 in the following cycle.
  - in_ready stays governed by the pre-flush count during the flush cycle.
- Empty: out_valid = 0 and pops are impossible.
- Full: in_ready = 0; in_pc and in_instr are ignored.
- Storage contents are not reset. Only the pointers and count are, and the outputs are masked by out_valid.
- Reset mid-operation drops all entries immediately, with no waiting for a clock edge.

Optional Feature:
- Macro IF_ID_QUEUE_BYPASS_EN.
- When defined, and count == 0 and in_valid = 1 and flush = 0:
  - out_valid = 1 combinationally in the same cycle.
  - out_pc, out_instr, out_pc_plus4 and out_misaligned are driven from in_pc/in_instr.
  - If out_ready = 1 in that cycle, the entry is consumed with no write and count stays 0.
  - If out_ready = 0, the entry is written normally.
  - This gives 0-cycle latency when the queue is empty.
- When undefined: no combinational path from in_* to out_*, and latency is always 1 cycle.

Test Plan:
- Reset check: assert rst_n=0 asynchronously between edges, then release.
  -> count=0, out_valid=0, out_pc=0, out_instr=0, in_ready=1 immediately.
- Single pass: push pc=0x00000000, instr=0x8C080004 with out_ready=0.
  -> next cycle out_valid=1, out_pc=0, out_instr=0x8C080004, out_pc_plus4=0x4, count=1.
- Fill and wrap: push 4 entries (pc 0x0,0x4,0x8,0xC) with out_ready=0.
  -> count=4, in_ready=0, and a 5th push at pc 0x10 is ignored.
  - Then pop 2 and push pc 0x10, 0x14.
  -> pops return 0x8 then 0xC, then 0x10 then 0x14 (pointer wrap correct).
- Simultaneous push/pop at count=2 for 6 cycles.
  -> count stays 2 and PCs are delivered in strict order with no duplicates or loss.
- Flush with push in the same cycle: count=3, flush=1, in_valid=1, pc=0x40.
  -> next cycle count=0, out_valid=0, and pc 0x40 is never delivered.
- Wrap and misalignment: push pc=0xFFFFFFFC, then pc=0x00000002.
  -> out_pc_plus4=0x00000000 with out_misaligned=0, then out_misaligned=1.
  - With IF_ID_QUEUE_BYPASS_EN, an empty queue plus in_valid=1 and out_ready=1 gives out_valid=1 in the same cycle and count stays 0.

Source files
------------

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID instruction queue; optional same-cycle bypass via IF_ID_QUEUE_BYPASS_EN
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc_plus4,
    output logic             out_misaligned,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Entry storage; deliberately not reset, head outputs are masked instead
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;

    logic             push;
    logic             pop;
    logic             wr_en;
    logic             rd_adv;
    logic             head_valid;
    logic [31:0]      head_pc;
    logic [31:0]      head_instr;

    // A full queue refuses input even when decode pops in the same cycle,
    // keeping in_ready free of any path from out_ready.
    assign in_ready = (cnt < CNT_FULL);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic bypass;

    // Empty queue with a live fetch: hand the fetched entry straight to decode
    assign bypass = (cnt == '0) & in_valid & ~flush;

    // A bypassed entry taken by decode is never stored; otherwise it is written as usual
    assign wr_en  = push & ~flush & ~(bypass & out_ready);
    assign rd_adv = pop & ~flush & ~bypass;

    // Head selection: stored oldest entry, or the fetch port while bypassing
    always_comb begin
        head_valid = (cnt != '0);
        head_pc    = pc_mem[rd_ptr];
        head_instr = instr_mem[rd_ptr];
        if (bypass) begin
            head_valid = 1'b1;
            head_pc    = in_pc;
            head_instr = in_instr;
        end
    end
`else
    // Flush wins over any transfer in the same cycle
    assign wr_en  = push & ~flush;
    assign rd_adv = pop & ~flush;

    // Head selection: always the stored oldest entry, giving one cycle of latency
    always_comb begin
        head_valid = (cnt != '0);
        head_pc    = pc_mem[rd_ptr];
        head_instr = instr_mem[rd_ptr];
    end
`endif

    // Write the accepted fetch entry into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_adv})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Decode-facing outputs; an invalid head reads as a zero NOP at PC 0
    always_comb begin
        out_valid      = head_valid;
        out_pc         = 32'h0;
        out_instr      = 32'h0;
        out_pc_plus4   = 32'h0;
        out_misaligned = 1'b0;
        if (head_valid) begin
            out_pc         = head_pc;
            out_instr      = head_instr;
            out_pc_plus4   = head_pc + 32'd4;
            out_misaligned = (head_pc[1:0] != 2'b00);
        end
    end

    assign count = cnt;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [31:0]    in_pc = '0;
    logic [31:0]    in_instr = '0;
    logic           flush = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [31:0]    out_pc;
    logic [31:0]    out_instr;
    logic [31:0]    out_pc_plus4;
    logic           out_misaligned;
    logic [PTR_W:0] count;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] mq[$];

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fl;
        logic        ordy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [2:0]  ecnt;
        logic        erdy;
    } vec_t;

    vec_t tbl[$];

    if_id_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_pc_plus4(out_pc_plus4), .out_misaligned(out_misaligned),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                                input logic fl, input logic ordy, input logic ev,
                                input logic [31:0] epc, input logic [31:0] einstr,
                                input logic [2:0] ecnt, input logic erdy);
        vec_t v;
        v.iv = iv; v.pc = pc; v.instr = instr; v.fl = fl; v.ordy = ordy;
        v.ev = ev; v.epc = epc; v.einstr = einstr; v.ecnt = ecnt; v.erdy = erdy;
        return v;
    endfunction

    function automatic logic model_bypass();
`ifdef IF_ID_QUEUE_BYPASS_EN
        return (mq.size() == 0) && in_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic fl, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic check_model();
        logic        byp;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        byp = model_bypass();
        ev  = (mq.size() != 0) || byp;
        epc = 32'h0;
        ein = 32'h0;
        if (byp) begin
            epc = in_pc;
            ein = in_instr;
        end else if (mq.size() != 0) begin
            epc = mq[0][63:32];
            ein = mq[0][31:0];
        end
        chk("m_out_valid", 32'(out_valid), 32'(ev));
        chk("m_out_pc", out_pc, epc);
        chk("m_out_instr", out_instr, ein);
        chk("m_out_pc_plus4", out_pc_plus4, ev ? epc + 32'd4 : 32'h0);
        chk("m_out_misaligned", 32'(out_misaligned), 32'(ev && (epc % 4 != 0)));
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    endtask

    task automatic model_edge();
        logic byp;
        logic acc;
        logic pv;
        byp = model_bypass();
        acc = in_valid && (mq.size() < DEPTH);
        pv  = ((mq.size() != 0) || byp) && out_ready;
        if (flush) begin
            mq.delete();
        end else if (byp) begin
            if (!out_ready) mq.push_back({in_pc, in_instr});
        end else begin
            if (pv) void'(mq.pop_front());
            if (acc) mq.push_back({in_pc, in_instr});
        end
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                        input logic fl, input logic ordy);
        drive(iv, pc, instr, fl, ordy);
        #4;
        check_model();
        advance();
    endtask

    initial begin
        logic [31:0] npc;

        // Reset asserted from time zero, checked between edges
        #2;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc_plus4", out_pc_plus4, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifndef IF_ID_QUEUE_BYPASS_EN
        // Single pass, fill, refused push when full, pointer wrap, drain
        tbl.push_back(mk(1'b1, 32'h0,  32'h8C080004, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        3'd0, 1'b1));
        tbl.push_back(mk(1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 32'h0,  32'h8C080004, 3'd1, 1'b1));
        tbl.push_back(mk(1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0,  32'h8C080004, 3'd1, 1'b1));
        tbl.push_back(mk(1'b1, 32'h0,  32'h24000000, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        3'd0, 1'b1));
        tbl.push_back(mk(1'b1, 32'h4,  32'h24000004, 1'b0, 1'b0, 1'b1, 32'h0,  32'h24000000, 3'd1, 1'b1));
        tbl.push_back(mk(1'b1, 32'h8,  32'h24000008, 1'b0, 1'b0, 1'b1, 32'h0,  32'h24000000, 3'd2, 1'b1));
        tbl.push_back(mk(1'b1, 32'hC,  32'h2400000C, 1'b0, 1'b0, 1'b1, 32'h0,  32'h24000000, 3'd3, 1'b1));
        tbl.push_back(mk(1'b1, 32'h10, 32'hDEAD0010, 1'b0, 1'b0, 1'b1, 32'h0,  32'h24000000, 3'd4, 1'b0));
        tbl.push_back(mk(1'b1, 32'h10, 32'hDEAD0010, 1'b0, 1'b1, 1'b1, 32'h0,  32'h24000000, 3'd4, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h4,  32'h24000004, 3'd3, 1'b1));
        tbl.push_back(mk(1'b1, 32'h10, 32'h24000010, 1'b0, 1'b0, 1'b1, 32'h8,  32'h24000008, 3'd2, 1'b1));
        tbl.push_back(mk(1'b1, 32'h14, 32'h24000014, 1'b0, 1'b0, 1'b1, 32'h8,  32'h24000008, 3'd3, 1'b1));
        tbl.push_back(mk(1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h8,  32'h24000008, 3'd4, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 32'hC,  32'h2400000C, 3'd3, 1'b1));
        tbl.push_back(mk(1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h10, 32'h24000010, 3'd2, 1'b1));
        tbl.push_back(mk(1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h14, 32'h24000014, 3'd1, 1'b1));
        tbl.push_back(mk(1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        3'd0, 1'b1));

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].pc, tbl[i].instr, tbl[i].fl, tbl[i].ordy);
            #4;
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
            chk($sformatf("tbl%0d_instr", i), out_instr, tbl[i].einstr);
            chk($sformatf("tbl%0d_plus4", i), out_pc_plus4, tbl[i].ev ? tbl[i].epc + 32'd4 : 32'h0);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
            advance();
        end
`endif

        // Flush at count 3 with a simultaneous push of pc 0x40
        step(1'b1, 32'h100, 32'h11110100, 1'b0, 1'b0);
        step(1'b1, 32'h104, 32'h11110104, 1'b0, 1'b0);
        step(1'b1, 32'h108, 32'h11110108, 1'b0, 1'b0);
        drive(1'b1, 32'h40, 32'h22220040, 1'b1, 1'b1);
        #4;
        check_model();
        chk("flush_count_before", 32'(count), 32'h3);
        chk("flush_in_ready", 32'(in_ready), 32'h1);
        advance();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #4;
        chk("flush_count_after", 32'(count), 32'h0);
        chk("flush_valid_after", 32'(out_valid), 32'h0);
        check_model();
        advance();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Simultaneous push and pop holding count at 2
        step(1'b1, 32'h200, 32'h33330200, 1'b0, 1'b0);
        step(1'b1, 32'h204, 32'h33330204, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'h208 + 32'(4 * k), 32'h33330208 + 32'(4 * k), 1'b0, 1'b1);
            #4;
            check_model();
            chk("pp_count", 32'(count), 32'h2);
            chk("pp_order", out_pc, 32'h200 + 32'(4 * k));
            advance();
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // PC+4 wraparound and misaligned head
        step(1'b1, 32'hFFFFFFFC, 32'h44440000, 1'b0, 1'b0);
        drive(1'b1, 32'h00000002, 32'h44440002, 1'b0, 1'b0);
        #4;
        check_model();
        chk("wrap_plus4", out_pc_plus4, 32'h0);
        chk("wrap_misaligned", 32'(out_misaligned), 32'h0);
        advance();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #4;
        check_model();
        chk("misaligned_head", 32'(out_misaligned), 32'h1);
        chk("misaligned_plus4", out_pc_plus4, 32'h6);
        advance();

`ifdef IF_ID_QUEUE_BYPASS_EN
        // Same-cycle bypass into an empty queue
        drive(1'b1, 32'h300, 32'h55550300, 1'b0, 1'b1);
        #4;
        chk("byp_valid", 32'(out_valid), 32'h1);
        chk("byp_pc", out_pc, 32'h300);
        check_model();
        advance();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #4;
        chk("byp_count", 32'(count), 32'h0);
        advance();
`endif

        // Asynchronous reset in the middle of operation
        step(1'b1, 32'h500, 32'h66660500, 1'b0, 1'b0);
        step(1'b1, 32'h504, 32'h66660504, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'h0);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_pc", out_pc, 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        mq.delete();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the queue model
        npc = 32'h1000;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            if ($urandom_range(0, 15) == 0) pc = $urandom;
            else pc = npc;
            step($urandom_range(0, 9) < 7, pc, $urandom, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 1) == 1);
            if (in_valid) npc = pc + 32'd4;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
